// File: rtl/dmem_arbiter.sv
// Two-port request/grant arbiter in front of a single-port synchronous data memory.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 first).
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_we0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wd0,
  input  logic          i_req1,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wd1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rd0,
  output logic [DW-1:0] o_rd1,
  output logic          o_mem_ce,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wd,
  input  logic [DW-1:0] i_mem_rd
);

  localparam int unsigned CW = 3;

  typedef enum logic [0:0] {S_IDLE, S_RWAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
`ifdef ARB_RR_EN
  logic          r_last;
`endif

  logic w_lat_hit;
  logic w_can_issue;
  logic w_win;
  logic w_issue;
  logic w_done;
  logic w_we;

  // Winner selection: w_win=1 means port 1 owns this cycle's command.
  always_comb begin
    w_lat_hit   = (r_cnt == CW'(READ_LAT));
    w_can_issue = (r_state == S_IDLE) || w_lat_hit;
`ifdef ARB_RR_EN
    w_win       = i_req1 && (!i_req0 || !r_last);
`else
    w_win       = i_req1 && !i_req0;
`endif
    w_issue     = w_can_issue && (i_req0 || i_req1) && !i_rst;
    w_done      = (r_state == S_RWAIT) && w_lat_hit && !i_rst;
    w_we        = w_win ? i_we1 : i_we0;
  end

  // Command and return steering; everything is forced low while reset is held.
  always_comb begin
    o_gnt0     = w_issue && !w_win;
    o_gnt1     = w_issue && w_win;
    o_mem_ce   = w_issue;
    o_mem_we   = w_issue && w_we;
    o_mem_addr = '0;
    o_mem_wd   = '0;
    if (w_issue) begin
      o_mem_addr = w_win ? i_addr1 : i_addr0;
      o_mem_wd   = w_win ? i_wd1 : i_wd0;
    end
    o_rvalid0  = w_done && !r_owner;
    o_rvalid1  = w_done && r_owner;
    o_rd0      = o_rvalid0 ? i_mem_rd : '0;
    o_rd1      = o_rvalid1 ? i_mem_rd : '0;
  end

  // A granted read opens a READ_LAT window; the completion cycle may grant again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
`ifdef ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      if (w_issue && !w_we) begin
        r_state <= S_RWAIT;
        r_cnt   <= CW'(1);
        r_owner <= w_win;
      end else if ((r_state == S_RWAIT) && !w_lat_hit) begin
        r_cnt   <= r_cnt + CW'(1);
      end else begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end
`ifdef ARB_RR_EN
      if (w_issue) r_last <= w_win;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances with READ_LAT 1, 2 and 3, each backed by a small memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0 [3];
  logic        we0  [3];
  logic [31:0] addr0[3];
  logic [31:0] wd0  [3];
  logic        req1 [3];
  logic        we1  [3];
  logic [31:0] addr1[3];
  logic [31:0] wd1  [3];
  logic        gnt0 [3];
  logic        gnt1 [3];
  logic        rv0  [3];
  logic        rv1  [3];
  logic [31:0] rd0  [3];
  logic [31:0] rd1  [3];
  logic        ce   [3];
  logic        mwe  [3];
  logic [31:0] maddr[3];
  logic [31:0] mwd  [3];
  logic [31:0] mrd  [3];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem  [64];
    logic [31:0] pipe [4];

    dmem_arbiter #(.AW(32), .DW(32), .READ_LAT(g + 1)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0[g]), .i_we0(we0[g]), .i_addr0(addr0[g]), .i_wd0(wd0[g]),
      .i_req1(req1[g]), .i_we1(we1[g]), .i_addr1(addr1[g]), .i_wd1(wd1[g]),
      .o_gnt0(gnt0[g]), .o_gnt1(gnt1[g]), .o_rvalid0(rv0[g]), .o_rvalid1(rv1[g]),
      .o_rd0(rd0[g]), .o_rd1(rd1[g]),
      .o_mem_ce(ce[g]), .o_mem_we(mwe[g]), .o_mem_addr(maddr[g]), .o_mem_wd(mwd[g]),
      .i_mem_rd(mrd[g])
    );

    always_ff @(posedge clk) begin
      if (ce[g] && mwe[g]) mem[maddr[g][7:2]] <= mwd[g];
      pipe[0] <= mem[maddr[g][7:2]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd[g] = pipe[g];
  end

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, ce, we;
    logic [31:0] ma, mwd;
    logic        v0, v1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    req0[k] = r0; we0[k] = w0; addr0[k] = a0; wd0[k] = d0;
    req1[k] = r1; we1[k] = w1; addr1[k] = a1; wd1[k] = d1;
  endtask

  logic [159:0] act_v;
  logic [159:0] exp_v;
  logic [3:0]   exp_g0;
  logic [3:0]   exp_g1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    //              r0    w0    a0        d0            r1    w1    a1        d1            g0    g1    ce    we    ma        mwd           v0    v1    rd0           rd1
    vt[0]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vt[4]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[5]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h12345678, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 32'h10, 32'h0BADF00D, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0BADF00D};
    vt[10] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};

    // Reset holds every output low even with a request pending.
    drive(0, 1'b1, 1'b1, 32'h40, 32'h55, 1'b1, 1'b0, 32'h44, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 160'({gnt0[0], gnt1[0]}), 160'(0));
    chk("rst_mem", 160'({ce[0], mwe[0], rv0[0], rv1[0]}), 160'(0));
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // Table-driven single-port traffic on the READ_LAT=1 instance.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(0, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
      #1;
      act_v = {gnt0[0], gnt1[0], ce[0], vt[i].ce ? mwe[0] : 1'b0,
               vt[i].ce ? maddr[0] : 32'h0, vt[i].ce ? mwd[0] : 32'h0,
               rv0[0], rv1[0], vt[i].v0 ? rd0[0] : 32'h0, vt[i].v1 ? rd1[0] : 32'h0};
      exp_v = {vt[i].g0, vt[i].g1, vt[i].ce, vt[i].we, vt[i].ma, vt[i].mwd,
               vt[i].v0, vt[i].v1, vt[i].rd0, vt[i].rd1};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Contention: both ports read continuously for four cycles.
`ifdef ARB_RR_EN
    exp_g0 = 4'b1010; exp_g1 = 4'b0101;
`else
    exp_g0 = 4'b1111; exp_g1 = 4'b0000;
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      chk($sformatf("cont_gnt%0d", c), 160'({gnt0[0], gnt1[0]}),
          160'({exp_g0[3-c], exp_g1[3-c]}));
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // READ_LAT=3: preload two words, then back-to-back reads on port 0.
    @(negedge clk); drive(2, 1'b1, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("l3_wr0", 160'({gnt0[2], mwe[2]}), 160'(2'b11));
    @(negedge clk); drive(2, 1'b1, 1'b1, 32'h4, 32'h44444444, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("l3_wr1", 160'({gnt0[2], mwe[2]}), 160'(2'b11));
    @(negedge clk); drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("l3_gntN", 160'({gnt0[2], ce[2], mwe[2]}), 160'(3'b110));
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); drive(2, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1; chk($sformatf("l3_wait%0d", c), 160'({gnt0[2], ce[2], rv0[2]}), 160'(0));
    end
    @(negedge clk);
    #1; chk("l3_N3", 160'({gnt0[2], ce[2], maddr[2], rv0[2], rd0[2]}),
            160'({2'b11, 32'h4, 1'b1, 32'h11111111}));
    @(negedge clk); drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("l3_N4", 160'({gnt0[2], rv0[2]}), 160'(0));
    @(negedge clk);
    #1; chk("l3_N5", 160'({gnt0[2], rv0[2]}), 160'(0));
    @(negedge clk);
    #1; chk("l3_N6", 160'({rv0[2], rd0[2], rv1[2]}), 160'({1'b1, 32'h44444444, 1'b0}));
    @(negedge clk);
    #1; chk("l3_N7", 160'({rv0[2], rv1[2]}), 160'(0));

    // READ_LAT=2 withdrawal: port 1 asks during the wait and drops before completion.
    @(negedge clk); drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("wd_gnt0", 160'({gnt0[1], gnt1[1]}), 160'(2'b10));
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    #1; chk("wd_wait", 160'({gnt1[1], ce[1], rv0[1]}), 160'(0));
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("wd_done", 160'({gnt1[1], ce[1], rv0[1], rv1[1]}), 160'(4'b0010));
    @(negedge clk);
    #1; chk("wd_after", 160'({gnt1[1], ce[1], rv0[1]}), 160'(0));

    // READ_LAT=2 reset mid-read: the read is dropped, the pending port 1 read goes first.
    @(negedge clk); drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("rs_gnt0", 160'({gnt0[1], ce[1]}), 160'(2'b11));
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    rst = 1'b1;
    #1; chk("rs_hold", 160'({gnt0[1], gnt1[1], ce[1], mwe[1], rv0[1], rv1[1], rd0[1], rd1[1]}), 160'(0));
    @(negedge clk); rst = 1'b0;
    #1; chk("rs_first", 160'({gnt1[1], gnt0[1], rv0[1]}), 160'(3'b100));
    @(negedge clk); drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; chk("rs_p1", 160'({rv0[1], rv1[1]}), 160'(0));
    @(negedge clk);
    #1; chk("rs_p2", 160'({rv0[1], rv1[1]}), 160'(2'b01));
    @(negedge clk);
    #1; chk("rs_p3", 160'({rv0[1], rv1[1], gnt0[1], gnt1[1]}), 160'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
